// File: rtl/cti8_pkg.sv
// Shared definitions for the CTI-8 fetch path: fetch FSM states, opcode
// length encoding and the PC power-up address.
package cti8_pkg;

  typedef enum logic [1:0] {
    FETCH_OP = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    HOLD     = 2'd3
  } fetch_state_t;

  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 6;

  localparam logic [1:0] LEN1 = 2'd1;
  localparam logic [1:0] LEN2 = 2'd2;
  localparam logic [1:0] LEN3 = 2'd3;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'hFE00;

  // Length field 2'b11 is reserved and treated as a single-byte opcode.
  function automatic logic [1:0] instr_len(input logic [7:0] opcode);
    case (opcode[LEN_MSB:LEN_LSB])
      2'b10:   instr_len = LEN3;
      2'b01:   instr_len = LEN2;
      default: instr_len = LEN1;
    endcase
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch stage: pulls opcode/operand bytes at the PC address and
// presents a complete instruction bundle to decode over valid/ready.
module fetch_sequencer
  import cti8_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic [15:0] pc_addr,
  output logic        pc_inc,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  input  logic        flush,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [7:0]  ir_opcode,
  output logic [15:0] ir_operand,
  output logic [1:0]  ir_len,
  output logic [15:0] ir_pc
);

  fetch_state_t state_q, state_d;
  logic [7:0]   opcode_q, opcode_d;
  logic [15:0]  operand_q, operand_d;
  logic [1:0]   len_q, len_d;
  logic [15:0]  pc_q, pc_d;
  logic         valid_q, valid_d;

  logic         accept;
  logic [1:0]   op_len;

  // A byte is consumed (and the PC bumped) only on a live, unflushed read.
  assign mem_rd   = (state_q != HOLD);
  assign accept   = mem_rd & mem_ready & clk_en & ~flush;
  assign pc_inc   = accept;
  assign mem_addr = pc_addr;
  assign op_len   = instr_len(mem_rdata);

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    len_d     = len_q;
    pc_d      = pc_q;
    valid_d   = valid_q;

    if (clk_en) begin
      if (flush) begin
        state_d = FETCH_OP;
        valid_d = 1'b0;
      end else begin
        case (state_q)
          FETCH_OP: begin
            if (accept) begin
              opcode_d  = mem_rdata;
              pc_d      = pc_addr;
              operand_d = 16'h0000;
              len_d     = op_len;
              if (op_len == LEN1) begin
                state_d = HOLD;
                valid_d = 1'b1;
              end else begin
                state_d = FETCH_LO;
              end
            end
          end
          FETCH_LO: begin
            if (accept) begin
              operand_d[7:0] = mem_rdata;
              if (len_q == LEN3) begin
                state_d = FETCH_HI;
              end else begin
                state_d = HOLD;
                valid_d = 1'b1;
              end
            end
          end
          FETCH_HI: begin
            if (accept) begin
              operand_d[15:8] = mem_rdata;
              state_d         = HOLD;
              valid_d         = 1'b1;
            end
          end
          HOLD: begin
            if (ir_ready) begin
              state_d = FETCH_OP;
              valid_d = 1'b0;
            end
          end
          default: begin
            state_d = FETCH_OP;
            valid_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH_OP;
      opcode_q  <= 8'h00;
      operand_q <= 16'h0000;
      len_q     <= LEN1;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      len_q     <= len_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
    end
  end

  assign ir_valid   = valid_q;
  assign ir_opcode  = opcode_q;
  assign ir_operand = operand_q;
  assign ir_len     = len_q;
  assign ir_pc      = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: emulates the PC and a byte memory,
// queues expected bundles as instructions are placed and checks them at HOLD.
module tb_fetch_sequencer;

  typedef struct {
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  len;
    logic [15:0] pc;
  } bundle_t;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic [15:0] pc_addr;
  logic        pc_inc;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        flush;
  logic        ir_valid;
  logic        ir_ready;
  logic [7:0]  ir_opcode;
  logic [15:0] ir_operand;
  logic [1:0]  ir_len;
  logic [15:0] ir_pc;

  logic [7:0]  mem [0:65535];
  bundle_t     sb[$];
  bundle_t     lastExp;
  int          errors;
  int          checks;
  int          incCount;
  int          nCyc;

  fetch_sequencer #(.RESET_PC(16'hFE00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .pc_addr   (pc_addr),
    .pc_inc    (pc_inc),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .flush     (flush),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .ir_opcode (ir_opcode),
    .ir_operand(ir_operand),
    .ir_len    (ir_len),
    .ir_pc     (ir_pc)
  );

  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock: samples pc_inc mid-cycle and advances the emulated PC on it.
  task automatic applyStimulus();
    logic incSeen;
    @(negedge clk);
    incSeen = pc_inc;
    if (pc_inc) incCount++;
    @(posedge clk);
    #1;
    if (incSeen) pc_addr = pc_addr + 16'd1;
  endtask

  task automatic pushExpected(input logic [7:0] op, input logic [15:0] operand,
                              input logic [1:0] len, input logic [15:0] pc);
    bundle_t b;
    b.opcode  = op;
    b.operand = operand;
    b.len     = len;
    b.pc      = pc;
    sb.push_back(b);
  endtask

  task automatic checkBundle(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, ir_valid}, 32'd1);
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      lastExp = sb.pop_front();
      checkOutput({tag, "_opcode"},  {24'd0, ir_opcode},  {24'd0, lastExp.opcode});
      checkOutput({tag, "_operand"}, {16'd0, ir_operand}, {16'd0, lastExp.operand});
      checkOutput({tag, "_len"},     {30'd0, ir_len},     {30'd0, lastExp.len});
      checkOutput({tag, "_pc"},      {16'd0, ir_pc},      {16'd0, lastExp.pc});
    end
  endtask

  task automatic waitValid(input int maxCycles, output int n);
    n = 0;
    while (!ir_valid && n < maxCycles) begin
      applyStimulus();
      n++;
    end
  endtask

  task automatic handshake(input string tag, input logic [15:0] nextPc);
    mem_ready = 1'b0;
    ir_ready  = 1'b1;
    applyStimulus();
    ir_ready = 1'b0;
    #1;
    checkOutput({tag, "_valid_drop"}, {31'd0, ir_valid}, 32'd0);
    checkOutput({tag, "_next_addr"}, {16'd0, mem_addr}, {16'd0, nextPc});
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    incCount  = 0;
    rst_n     = 1'b0;
    clk_en    = 1'b0;
    flush     = 1'b0;
    ir_ready  = 1'b0;
    mem_ready = 1'b0;
    pc_addr   = 16'hFE00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFE00] = 8'h00;
    mem[16'hFE01] = 8'h80; mem[16'hFE02] = 8'h34; mem[16'hFE03] = 8'h12;
    mem[16'hFE04] = 8'h41; mem[16'hFE05] = 8'hAB;
    mem[16'hFE06] = 8'h80; mem[16'hFE07] = 8'h55;
    mem[16'h1000] = 8'hC5;
    mem[16'h1001] = 8'h82; mem[16'h1002] = 8'hCD; mem[16'h1003] = 8'hEF;
    mem[16'h1004] = 8'h07;

    // Reset is taken even with clk_en low.
    applyStimulus();
    applyStimulus();
    rst_n  = 1'b1;
    clk_en = 1'b1;
    #1;
    checkOutput("rst_valid",   {31'd0, ir_valid},   32'd0);
    checkOutput("rst_opcode",  {24'd0, ir_opcode},  32'd0);
    checkOutput("rst_operand", {16'd0, ir_operand}, 32'd0);
    checkOutput("rst_len",     {30'd0, ir_len},     32'd1);
    checkOutput("rst_pc",      {16'd0, ir_pc},      32'hFE00);
    checkOutput("rst_mem_rd",  {31'd0, mem_rd},     32'd1);
    checkOutput("rst_addr",    {16'd0, mem_addr},   32'hFE00);

    // 1-byte instruction 00 at FE00.
    pushExpected(8'h00, 16'h0000, 2'd1, 16'hFE00);
    mem_ready = 1'b1;
    #1;
    checkOutput("t1_inc", {31'd0, pc_inc}, 32'd1);
    applyStimulus();
    mem_ready = 1'b0;
    #1;
    checkBundle("t1");
    checkOutput("t1_hold_mem_rd", {31'd0, mem_rd}, 32'd0);
    handshake("t1", 16'hFE01);

    // 3-byte instruction 80 34 12, decode stalls for two cycles.
    pushExpected(8'h80, 16'h1234, 2'd3, 16'hFE01);
    incCount  = 0;
    mem_ready = 1'b1;
    waitValid(10, nCyc);
    checkOutput("t2_latency", nCyc, 32'd3);
    checkOutput("t2_incs", incCount, 32'd3);
    checkBundle("t2");
    applyStimulus();
    applyStimulus();
    checkOutput("t2_held_valid", {31'd0, ir_valid}, 32'd1);
    checkOutput("t2_held_operand", {16'd0, ir_operand}, {16'd0, lastExp.operand});
    checkOutput("t2_held_incs", incCount, 32'd3);
    handshake("t2", 16'hFE04);

    // 2-byte instruction 41 AB with a wait state on the operand byte.
    pushExpected(8'h41, 16'h00AB, 2'd2, 16'hFE04);
    incCount  = 0;
    mem_ready = 1'b1;
    applyStimulus();
    mem_ready = 1'b0;
    #1;
    checkOutput("t3_wait_inc", {31'd0, pc_inc}, 32'd0);
    applyStimulus();
    checkOutput("t3_wait_valid", {31'd0, ir_valid}, 32'd0);
    mem_ready = 1'b1;
    applyStimulus();
    checkBundle("t3");
    checkOutput("t3_incs", incCount, 32'd2);
    handshake("t3", 16'hFE06);

    // Flush after the opcode of a 3-byte instruction; PC rewritten to 1000.
    mem_ready = 1'b1;
    applyStimulus();
    flush   = 1'b1;
    pc_addr = 16'h1000;
    #1;
    checkOutput("t4_flush_inc", {31'd0, pc_inc}, 32'd0);
    applyStimulus();
    flush     = 1'b0;
    mem_ready = 1'b0;
    #1;
    checkOutput("t4_flush_valid", {31'd0, ir_valid}, 32'd0);
    checkOutput("t4_flush_addr", {16'd0, mem_addr}, 32'h1000);
    pushExpected(8'hC5, 16'h0000, 2'd1, 16'h1000);
    mem_ready = 1'b1;
    waitValid(10, nCyc);
    checkOutput("t4_latency", nCyc, 32'd1);
    checkBundle("t4");
    handshake("t4", 16'h1001);

    // clk_en low for three cycles while in FETCH_HI with data ready.
    pushExpected(8'h82, 16'hEFCD, 2'd3, 16'h1001);
    incCount  = 0;
    mem_ready = 1'b1;
    applyStimulus();
    applyStimulus();
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("t5_frozen_inc", {31'd0, pc_inc}, 32'd0);
      applyStimulus();
    end
    checkOutput("t5_frozen_valid", {31'd0, ir_valid}, 32'd0);
    checkOutput("t5_frozen_mem_rd", {31'd0, mem_rd}, 32'd1);
    checkOutput("t5_frozen_addr", {16'd0, mem_addr}, 32'h1003);
    clk_en = 1'b1;
    applyStimulus();
    checkBundle("t5");
    checkOutput("t5_incs", incCount, 32'd3);

    // Handshake ignored while clk_en is low.
    mem_ready = 1'b0;
    clk_en    = 1'b0;
    ir_ready  = 1'b1;
    applyStimulus();
    checkOutput("t5_noen_hs_valid", {31'd0, ir_valid}, 32'd1);

    // Flush in HOLD drops the bundle even with ir_ready high.
    clk_en = 1'b1;
    flush  = 1'b1;
    applyStimulus();
    flush    = 1'b0;
    ir_ready = 1'b0;
    #1;
    checkOutput("t5_flush_hold_valid", {31'd0, ir_valid}, 32'd0);
    checkOutput("t5_flush_hold_mem_rd", {31'd0, mem_rd}, 32'd1);

    // Reset while holding a valid bundle.
    pushExpected(8'h07, 16'h0000, 2'd1, 16'h1004);
    mem_ready = 1'b1;
    waitValid(10, nCyc);
    checkBundle("t6");
    mem_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkOutput("t6_rst_inc", {31'd0, pc_inc}, 32'd0);
    applyStimulus();
    rst_n   = 1'b1;
    pc_addr = 16'hFE00;
    #1;
    checkOutput("t6_rst_valid",  {31'd0, ir_valid},  32'd0);
    checkOutput("t6_rst_pc",     {16'd0, ir_pc},     32'hFE00);
    checkOutput("t6_rst_opcode", {24'd0, ir_opcode}, 32'd0);
    checkOutput("t6_rst_len",    {30'd0, ir_len},    32'd1);
    checkOutput("t6_rst_mem_rd", {31'd0, mem_rd},    32'd1);

    checkOutput("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
